// File: rtl/bisync_param_queue.sv
// -----------------------------------------------------------------------------
// bisync_param_queue
//
// Bisynchronous FIFO between a write domain (w_clk) and a read domain (r_clk)
// whose clocks are ratiochronous: every edge of one clock has a fixed, known
// timing relationship with the other. There are no synchronizers and no gray
// code. Every path that crosses between the domains is closed by static timing.
//
// The RAM depth may be any value >= 2; it does not have to be a power of two.
// Each pointer runs 0..N-1 and carries a wrap bit. Occupancy counts and
// watermark flags are provided in both domains. An optional one-entry output
// register on r_clk gives a registered read port and adds one entry of
// capacity.
//
// Parameters
//   p_data_width   payload width
//   p_num_entries  RAM entries (N), >= 2
//   p_almost_full  w_almost_full when w_count >= this (1..N)
//   p_almost_empty r_almost_empty when r_count <= this (0..N)
//   p_rd_reg       0: combinational read port, 1: registered read port
//
// Ports (CW = $clog2(N + p_rd_reg + 1))
//   w_clk          in   write-domain clock
//   r_clk          in   read-domain clock
//   reset          in   synchronous active-high reset, sampled by both clocks
//   w_val          in   write request
//   w_rdy          out  RAM not full
//   w_msg          in   write payload
//   w_count        out  RAM occupancy, write-domain view
//   w_almost_full  out  w_count >= p_almost_full
//   r_val          out  read data valid
//   r_rdy          in   consumer ready
//   r_msg          out  read payload
//   r_count        out  RAM occupancy plus output register, read-domain view
//   r_almost_empty out  r_count <= p_almost_empty
// -----------------------------------------------------------------------------
module bisync_param_queue #(
    parameter int p_data_width   = 32,
    parameter int p_num_entries  = 6,
    parameter int p_almost_full  = 5,
    parameter int p_almost_empty = 1,
    parameter int p_rd_reg       = 0
) (
    input  logic                                          w_clk,
    input  logic                                          r_clk,
    input  logic                                          reset,
    input  logic                                          w_val,
    output logic                                          w_rdy,
    input  logic [p_data_width-1:0]                       w_msg,
    output logic [$clog2(p_num_entries+p_rd_reg+1)-1:0]   w_count,
    output logic                                          w_almost_full,
    output logic                                          r_val,
    input  logic                                          r_rdy,
    output logic [p_data_width-1:0]                       r_msg,
    output logic [$clog2(p_num_entries+p_rd_reg+1)-1:0]   r_count,
    output logic                                          r_almost_empty
);

    localparam int N  = p_num_entries;
    localparam int DW = p_data_width;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(p_num_entries + p_rd_reg + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
    localparam logic [CW-1:0] N_C      = CW'(N);
    localparam logic [CW-1:0] AF_C     = CW'(p_almost_full);
    localparam logic [CW-1:0] AE_C     = CW'(p_almost_empty);

    // Storage. Only the write domain writes the RAM. The read domain reads it
    // combinationally at r_ptr_q.
    logic [DW-1:0] mem_q [N];

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic          w_wrap_q, w_wrap_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic          r_wrap_q, r_wrap_d;

    logic          ptr_eq;
    logic          empty;
    logic          full;
    logic          w_go;
    logic          r_go;
    logic          r_bump;      // read pointer advances on this r_clk edge
    logic          oreg_occ;    // output register holds an entry
    logic [CW-1:0] ram_count;

    // -------------------------------------------------------------------------
    // Status, derived combinationally from both pointer registers.
    // The same logic serves both domains. Each crossing path is a timed path.
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_eq = (w_ptr_q == r_ptr_q);
        empty  = ptr_eq && (w_wrap_q == r_wrap_q);
        full   = ptr_eq && (w_wrap_q != r_wrap_q);
        // When the wrap bits are equal, the writer has not lapped the reader.
        // When they differ, the writer is one lap ahead. In that case,
        // w_ptr <= r_ptr, and N - r + w stays within 0..N.
        if (w_wrap_q == r_wrap_q) begin
            ram_count = CW'(w_ptr_q) - CW'(r_ptr_q);
        end else begin
            ram_count = N_C - CW'(r_ptr_q) + CW'(w_ptr_q);
        end
    end

    assign w_rdy          = !full;
    assign w_go           = w_val && w_rdy;
    assign w_count        = ram_count;
    assign w_almost_full  = (ram_count >= AF_C);
    assign r_count        = ram_count + CW'(oreg_occ);
    assign r_almost_empty = (r_count <= AE_C);
    assign r_go           = r_val && r_rdy;

    // -------------------------------------------------------------------------
    // Write domain
    // -------------------------------------------------------------------------
    always_comb begin
        w_ptr_d  = w_ptr_q;
        w_wrap_d = w_wrap_q;
        if (w_go) begin
            if (w_ptr_q == PTR_LAST) begin
                w_ptr_d  = '0;
                w_wrap_d = !w_wrap_q;
            end else begin
                w_ptr_d  = w_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (reset) begin
            w_ptr_q  <= '0;
            w_wrap_q <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            w_wrap_q <= w_wrap_d;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_go) begin
            mem_q[w_ptr_q] <= w_msg;
        end
    end

    // -------------------------------------------------------------------------
    // Read domain: pointer
    // -------------------------------------------------------------------------
    always_comb begin
        r_ptr_d  = r_ptr_q;
        r_wrap_d = r_wrap_q;
        if (r_bump) begin
            if (r_ptr_q == PTR_LAST) begin
                r_ptr_d  = '0;
                r_wrap_d = !r_wrap_q;
            end else begin
                r_ptr_d  = r_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_ptr_q  <= '0;
            r_wrap_q <= 1'b0;
        end else begin
            r_ptr_q  <= r_ptr_d;
            r_wrap_q <= r_wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read domain: output port
    // -------------------------------------------------------------------------
    if (p_rd_reg == 0) begin : g_comb_rd
        // The head of the RAM is presented directly. r_val follows the write
        // pointer through the empty compare, so it can rise without an r_clk
        // edge.
        assign r_val    = !empty;
        assign r_msg    = mem_q[r_ptr_q];
        assign r_bump   = r_go;
        assign oreg_occ = 1'b0;
    end else begin : g_reg_rd
        logic          oreg_val_q, oreg_val_d;
        logic [DW-1:0] oreg_msg_q, oreg_msg_d;

        // Refill whenever the register is free or is being consumed this edge
        // and the RAM holds an entry. A consume with nothing to refill empties
        // the register.
        always_comb begin
            r_bump     = (!oreg_val_q || r_go) && !empty;
            oreg_val_d = oreg_val_q;
            oreg_msg_d = oreg_msg_q;
            if (r_bump) begin
                oreg_val_d = 1'b1;
                oreg_msg_d = mem_q[r_ptr_q];
            end else if (r_go) begin
                oreg_val_d = 1'b0;
            end
        end

        // The payload is cleared on reset so that r_msg reads 0 afterwards.
        always_ff @(posedge r_clk) begin
            if (reset) begin
                oreg_val_q <= 1'b0;
                oreg_msg_q <= '0;
            end else begin
                oreg_val_q <= oreg_val_d;
                oreg_msg_q <= oreg_msg_d;
            end
        end

        assign r_val    = oreg_val_q;
        assign r_msg    = oreg_msg_q;
        assign oreg_occ = oreg_val_q;
    end

`ifndef SYNTHESIS
    // -------------------------------------------------------------------------
    // Simulation checks: parameter legality and X-free payload on handshakes
    // -------------------------------------------------------------------------
    always_ff @(posedge w_clk) begin
        if (reset) begin
            assert (p_num_entries >= 2 &&
                    p_almost_full >= 1 && p_almost_full <= p_num_entries &&
                    p_almost_empty >= 0 && p_almost_empty <= p_num_entries &&
                    (p_rd_reg == 0 || p_rd_reg == 1))
            else $error("bisync_param_queue: illegal parameter set");
        end else if (w_go) begin
            assert (!$isunknown(w_msg))
            else $error("bisync_param_queue: w_msg unknown on write");
        end
    end

    always_ff @(posedge r_clk) begin
        if (!reset && r_go) begin
            assert (!$isunknown(r_msg))
            else $error("bisync_param_queue: r_msg unknown on read");
        end
    end
`endif

endmodule
